// File: rtl/clock_pkg.sv
// Shared constants and state encoding for the clock top level and its alarm sequencer.
package clock_pkg;

    localparam int NS = 60;
    localparam int NH = 24;
    localparam int NW = 7;

    localparam logic [NW-1:0] DAY_MASK = 7'b0011111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_snooze_edge_det.sv
// Registered rising-edge one-shot for a level button synchronous to clk.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev  <= 1'b0;
            press <= 1'b0;
        end else begin
            prev  <= btn;
            press <= btn & ~prev;
        end
    end

endmodule

// File: rtl/alarm_snooze.sv
// Alarm sequencer: weekday-masked match, auto-silence timeout and bounded snooze.
// Clocked by the 1 Hz pulse, so the timer counts seconds.
module alarm_snooze #(
    parameter int                         NS         = clock_pkg::NS,
    parameter int                         NH         = clock_pkg::NH,
    parameter int                         NW         = clock_pkg::NW,
    parameter logic [NW-1:0]              DAY_MASK   = clock_pkg::DAY_MASK,
    parameter int                         RING_SEC   = 60,
    parameter int                         SNOOZE_SEC = 540,
    parameter int                         MAX_SNOOZE = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [6:0]                        tsec,
    input  logic [6:0]                        tmin,
    input  logic [6:0]                        thrs,
    input  logic [6:0]                        tday,
    input  logic [6:0]                        amin,
    input  logic [6:0]                        ahrs,
    input  logic                              alarmon,
    input  logic                              snooze_btn,
    input  logic                              dismiss_btn,
    output logic                              buzz,
    output logic                              snoozing,
    output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_ct
);

    import clock_pkg::alarm_state_t;
    import clock_pkg::IDLE;
    import clock_pkg::RING;
    import clock_pkg::SNOOZE;
    import clock_pkg::max_int;

    localparam int TW = $clog2(max_int(RING_SEC, SNOOZE_SEC));
    localparam int CW = $clog2(MAX_SNOOZE + 1);
    localparam int DW = $clog2(NW);
    localparam int MW = 2 ** DW;

    localparam logic [TW-1:0] RING_LOAD   = TW'(RING_SEC - 1);
    localparam logic [TW-1:0] SNOOZE_LOAD = TW'(SNOOZE_SEC - 1);
    localparam logic [CW-1:0] MAX_CT      = CW'(MAX_SNOOZE);
    // Mask padded to a power of two so the day index never reads past the vector.
    localparam logic [MW-1:0] MASK_EXT    = MW'(DAY_MASK);

    alarm_state_t  state;
    logic [TW-1:0] timer;
    logic          snooze_press;
    logic          dismiss_press;
    logic          day_ok;
    logic          time_ok;
    logic          match;

    edge_det u_snooze_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (snooze_btn),
        .press (snooze_press)
    );

    edge_det u_dismiss_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (dismiss_btn),
        .press (dismiss_press)
    );

    assign day_ok  = (tday < 7'(NW)) && MASK_EXT[tday[DW-1:0]];
    assign time_ok = (tmin < 7'(NS)) && (thrs < 7'(NH));
    assign match   = alarmon && (tsec == 7'd0) && (tmin == amin) && (thrs == ahrs)
                     && day_ok && time_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            timer     <= '0;
            snooze_ct <= '0;
            buzz      <= 1'b0;
            snoozing  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state <= RING;
                        timer <= RING_LOAD;
                        buzz  <= 1'b1;
                    end
                end
                RING: begin
                    if (!alarmon || dismiss_press) begin
                        state     <= IDLE;
                        timer     <= '0;
                        snooze_ct <= '0;
                        buzz      <= 1'b0;
                        snoozing  <= 1'b0;
                    end else if (snooze_press && (snooze_ct < MAX_CT)) begin
                        state     <= SNOOZE;
                        timer     <= SNOOZE_LOAD;
                        snooze_ct <= snooze_ct + 1'b1;
                        buzz      <= 1'b0;
                        snoozing  <= 1'b1;
                    end else if (timer == '0) begin
                        state     <= IDLE;
                        snooze_ct <= '0;
                        buzz      <= 1'b0;
                        snoozing  <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                SNOOZE: begin
                    if (!alarmon || dismiss_press) begin
                        state     <= IDLE;
                        timer     <= '0;
                        snooze_ct <= '0;
                        buzz      <= 1'b0;
                        snoozing  <= 1'b0;
                    end else if (timer == '0) begin
                        state    <= RING;
                        timer    <= RING_LOAD;
                        buzz     <= 1'b1;
                        snoozing <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    timer     <= '0;
                    snooze_ct <= '0;
                    buzz      <= 1'b0;
                    snoozing  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_snooze.sv
// Directed bench for alarm_snooze: match vectors from a table plus multi-cycle sequences.
module tb_alarm_snooze;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] tsec = '0, tmin = '0, thrs = '0, tday = '0, amin = '0, ahrs = '0;
    logic       alarmon = 1'b0, snooze_btn = 1'b0, dismiss_btn = 1'b0;
    logic       buzz, snoozing;
    logic [1:0] snooze_ct;

    int total = 0;
    int bad   = 0;
    int t_sec = 0, t_min = 0, t_hrs = 0;
    bit run_clock = 1'b0;

    typedef struct {
        string      name;
        logic [6:0] day;
        logic       on;
        logic [6:0] sec;
        logic [6:0] mn;
        logic [6:0] hr;
        logic       exp_buzz;
    } vec_t;

    vec_t vecs[12];

    alarm_snooze dut (
        .clk         (clk),
        .rst         (rst),
        .tsec        (tsec),
        .tmin        (tmin),
        .thrs        (thrs),
        .tday        (tday),
        .amin        (amin),
        .ahrs        (ahrs),
        .alarmon     (alarmon),
        .snooze_btn  (snooze_btn),
        .dismiss_btn (dismiss_btn),
        .buzz        (buzz),
        .snoozing    (snoozing),
        .snooze_ct   (snooze_ct)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_time();
        tsec = 7'(t_sec);
        tmin = 7'(t_min);
        thrs = 7'(t_hrs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (run_clock) begin
            t_sec++;
            if (t_sec == 60) begin t_sec = 0; t_min++; end
            if (t_min == 60) begin t_min = 0; t_hrs++; end
            if (t_hrs == 24) t_hrs = 0;
            drive_time();
        end
    endtask

    task automatic do_reset();
        #1 rst = 1'b0;
        #1 rst = 1'b1;
    endtask

    // Leaves 07:30:00 sampled by the last edge; buzz is valid right after.
    task automatic arm(input int day);
        do_reset();
        tday = 7'(day);
        alarmon = 1'b1;
        amin = 7'd30;
        ahrs = 7'd7;
        t_hrs = 7; t_min = 29; t_sec = 58;
        drive_time();
        run_clock = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic press_snooze();
        snooze_btn = 1'b1;
        tick();
        snooze_btn = 1'b0;
        tick();
    endtask

    task automatic wait_ring(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!buzz && n < 700);
    endtask

    initial begin
        int n;
        int hits;

        #1;
        chk("reset_buzz", int'(buzz), 0);
        chk("reset_snoozing", int'(snoozing), 0);
        chk("reset_ct", int'(snooze_ct), 0);
        #1 rst = 1'b1;

        vecs[0]  = '{"day1_hit",     7'd1, 1'b1, 7'd0, 7'd30, 7'd7,  1'b1};
        vecs[1]  = '{"day0_hit",     7'd0, 1'b1, 7'd0, 7'd30, 7'd7,  1'b1};
        vecs[2]  = '{"day4_hit",     7'd4, 1'b1, 7'd0, 7'd30, 7'd7,  1'b1};
        vecs[3]  = '{"day5_masked",  7'd5, 1'b1, 7'd0, 7'd30, 7'd7,  1'b0};
        vecs[4]  = '{"day6_masked",  7'd6, 1'b1, 7'd0, 7'd30, 7'd7,  1'b0};
        vecs[5]  = '{"day7_range",   7'd7, 1'b1, 7'd0, 7'd30, 7'd7,  1'b0};
        vecs[6]  = '{"day8_range",   7'd8, 1'b1, 7'd0, 7'd30, 7'd7,  1'b0};
        vecs[7]  = '{"alarm_off",    7'd1, 1'b0, 7'd0, 7'd30, 7'd7,  1'b0};
        vecs[8]  = '{"sec1_miss",    7'd1, 1'b1, 7'd1, 7'd30, 7'd7,  1'b0};
        vecs[9]  = '{"min31_miss",   7'd1, 1'b1, 7'd0, 7'd31, 7'd7,  1'b0};
        vecs[10] = '{"hr8_miss",     7'd1, 1'b1, 7'd0, 7'd30, 7'd8,  1'b0};
        vecs[11] = '{"hr19_miss",    7'd1, 1'b1, 7'd0, 7'd30, 7'd19, 1'b0};

        amin = 7'd30;
        ahrs = 7'd7;
        for (int i = 0; i < 12; i++) begin
            run_clock = 1'b0;
            do_reset();
            tday = vecs[i].day;
            alarmon = vecs[i].on;
            tsec = vecs[i].sec;
            tmin = vecs[i].mn;
            thrs = vecs[i].hr;
            tick();
            chk(vecs[i].name, int'(buzz), int'(vecs[i].exp_buzz));
        end

        // Ring then auto-silence after 60 s, no re-ring as the minute moves on.
        arm(1);
        n = int'(buzz);
        for (int i = 0; i < 200 && buzz; i++) begin
            tick();
            if (buzz) n++;
        end
        chk("ring_len", n, 60);
        chk("timeout_ct", int'(snooze_ct), 0);
        hits = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (buzz) hits++;
        end
        chk("no_retrigger", hits, 0);

        // Masked weekday through the whole alarm minute.
        arm(5);
        hits = int'(buzz);
        for (int i = 0; i < 70; i++) begin
            tick();
            if (buzz) hits++;
        end
        chk("mask_day5", hits, 0);

        // Snooze press at cycle 5 of ringing.
        arm(1);
        chk("snz_ring0", int'(buzz), 1);
        tick(); tick(); tick(); tick();
        snooze_btn = 1'b1;
        tick();
        chk("snz_press_lat", int'(buzz), 1);
        snooze_btn = 1'b0;
        tick();
        chk("snz_buzz", int'(buzz), 0);
        chk("snz_snoozing", int'(snoozing), 1);
        chk("snz_ct", int'(snooze_ct), 1);
        wait_ring(n);
        chk("snz_rering", n, 540);
        chk("snz_rering_flag", int'(snoozing), 0);

        // Three snoozes, fourth ignored, then dismiss.
        arm(1);
        for (int k = 0; k < 3; k++) begin
            press_snooze();
            chk("lim_snoozing", int'(snoozing), 1);
            wait_ring(n);
            chk("lim_rering", n, 540);
        end
        chk("lim_ct3", int'(snooze_ct), 3);
        press_snooze();
        chk("lim_4th_buzz", int'(buzz), 1);
        chk("lim_4th_snoozing", int'(snoozing), 0);
        chk("lim_4th_ct", int'(snooze_ct), 3);
        dismiss_btn = 1'b1;
        tick();
        dismiss_btn = 1'b0;
        tick();
        chk("dismiss_buzz", int'(buzz), 0);
        chk("dismiss_ct", int'(snooze_ct), 0);

        // Simultaneous snooze and dismiss: dismiss wins.
        arm(1);
        tick();
        snooze_btn = 1'b1;
        dismiss_btn = 1'b1;
        tick();
        snooze_btn = 1'b0;
        dismiss_btn = 1'b0;
        tick();
        chk("both_buzz", int'(buzz), 0);
        chk("both_snoozing", int'(snoozing), 0);
        chk("both_ct", int'(snooze_ct), 0);

        // Dropping alarmon during snooze ends the event for good.
        arm(1);
        press_snooze();
        chk("off_pre_snoozing", int'(snoozing), 1);
        alarmon = 1'b0;
        tick();
        chk("off_snoozing", int'(snoozing), 0);
        chk("off_ct", int'(snooze_ct), 0);
        alarmon = 1'b1;
        hits = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (buzz) hits++;
        end
        chk("off_no_rering", hits, 0);

        // Async reset mid-ring, with snooze held across it.
        arm(1);
        tick(); tick();
        chk("ar_pre_buzz", int'(buzz), 1);
        snooze_btn = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("ar_buzz", int'(buzz), 0);
        chk("ar_ct", int'(snooze_ct), 0);
        rst = 1'b1;
        #1 snooze_btn = 1'b0;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (buzz || snoozing) hits++;
        end
        chk("ar_quiet", hits, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
